// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator car controller.
// Floor vectors are widened to MAX_FLOORS so one helper fits any car size.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MOVE_UP,
    MOVE_DOWN,
    DOOR
  } car_state_t;

  localparam int MAX_FLOORS = 10;
  localparam int TMR_W      = 8;

  typedef logic [MAX_FLOORS-1:0] floor_vec_t;

  function automatic logic any_above(
    input floor_vec_t p,
    input logic [3:0] f
  );
    logic r;
    r = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if (i > int'(f) && p[i]) r = 1'b1;
    end
    return r;
  endfunction

  function automatic logic any_below(
    input floor_vec_t p,
    input logic [3:0] f
  );
    logic r;
    r = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if (i < int'(f) && p[i]) r = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/elevator_tick_timer.sv
// Loadable tick down-counter shared by the travel and door phases.
// done pulses on the tick that takes the count from 1 to 0.
module elevator_tick_timer
  import elevator_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             tick,
  output logic             done
);

  logic [TMR_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (tick && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign done = tick && (r_cnt == TMR_W'(1));

endmodule

// File: rtl/elevator_car_ctrl.sv
// Elevator car controller: latches calls, steps the car one floor
// at a time, holds the door at served floors, shows floor as BCD.
module elevator_car_ctrl
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS   = 6,
  parameter int TRAVEL_TICKS = 4,
  parameter int DOOR_TICKS   = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tick,
  input  logic [NUM_FLOORS-1:0] call_req,
  output logic [3:0]            floor_bcd,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  door_open,
  output logic                  moving_up,
  output logic                  moving_down
);

  localparam logic [3:0] TOP_FLOOR = 4'(NUM_FLOORS - 1);
  localparam logic [TMR_W-1:0] TRAVEL_LD = TMR_W'(TRAVEL_TICKS);
  localparam logic [TMR_W-1:0] DOOR_LD   = TMR_W'(DOOR_TICKS);

  car_state_t r_state;
  car_state_t w_state_nx;
  car_state_t w_dec_state;

  logic [3:0] r_floor;
  logic [3:0] w_floor_nx;
  logic [3:0] w_step_floor;
  logic [3:0] w_serve_floor;

  logic r_dir_up;
  logic w_dir_nx;
  logic w_dec_dir;

  logic [NUM_FLOORS-1:0] r_pending;
  logic [NUM_FLOORS-1:0] w_served;
  floor_vec_t            w_pend_ext;
  floor_vec_t            w_call_ext;

  logic             w_above;
  logic             w_below;
  logic             w_decide;
  logic             w_serve;
  logic             w_load;
  logic             w_done;
  logic [TMR_W-1:0] w_load_val;

  elevator_tick_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (w_load),
    .load_val (w_load_val),
    .tick     (tick),
    .done     (w_done)
  );

  always_comb begin
    w_pend_ext = '0;
    w_pend_ext[NUM_FLOORS-1:0] = r_pending;
    w_call_ext = '0;
    w_call_ext[NUM_FLOORS-1:0] = call_req;
  end

  assign w_above = any_above(w_pend_ext, r_floor);
  assign w_below = any_below(w_pend_ext, r_floor);

  assign w_step_floor = (r_state == MOVE_UP) ?
                        r_floor + 4'd1 :
                        r_floor - 4'd1;

  // Prefer the current heading; reverse only when nothing lies ahead.
  always_comb begin
    w_dec_state = IDLE;
    w_dec_dir   = r_dir_up;
    if (w_pend_ext[r_floor]) begin
      w_dec_state = DOOR;
    end else if (r_dir_up && w_above) begin
      w_dec_state = MOVE_UP;
    end else if (!r_dir_up && w_below) begin
      w_dec_state = MOVE_DOWN;
    end else if (w_below) begin
      w_dec_state = MOVE_DOWN;
      w_dec_dir   = 1'b0;
    end else if (w_above) begin
      w_dec_state = MOVE_UP;
      w_dec_dir   = 1'b1;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_floor_nx    = r_floor;
    w_dir_nx      = r_dir_up;
    w_decide      = 1'b0;
    w_serve       = 1'b0;
    w_serve_floor = r_floor;
    w_load        = 1'b0;
    w_load_val    = TRAVEL_LD;

    unique case (r_state)
      IDLE: begin
        w_decide = 1'b1;
      end
      MOVE_UP, MOVE_DOWN: begin
        if (w_done) begin
          if ((r_state == MOVE_UP && r_floor == TOP_FLOOR) ||
              (r_state == MOVE_DOWN && r_floor == 4'd0)) begin
            w_state_nx = IDLE;
          end else begin
            w_floor_nx = w_step_floor;
            w_load     = 1'b1;
            if (w_pend_ext[w_step_floor]) begin
              w_state_nx    = DOOR;
              w_load_val    = DOOR_LD;
              w_serve       = 1'b1;
              w_serve_floor = w_step_floor;
            end
          end
        end
      end
      DOOR: begin
        // Calls at an open door only restart it; they never latch.
        w_serve = 1'b1;
        if (w_call_ext[r_floor]) begin
          w_load     = 1'b1;
          w_load_val = DOOR_LD;
        end else if (w_done) begin
          w_decide = 1'b1;
        end
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase

    if (w_decide) begin
      w_state_nx = w_dec_state;
      w_dir_nx   = w_dec_dir;
      unique case (w_dec_state)
        DOOR: begin
          w_load     = 1'b1;
          w_load_val = DOOR_LD;
          w_serve    = 1'b1;
        end
        MOVE_UP, MOVE_DOWN: begin
          w_load     = 1'b1;
          w_load_val = TRAVEL_LD;
        end
        default: begin
          w_load = 1'b0;
        end
      endcase
    end
  end

  assign w_served = w_serve ?
                    (NUM_FLOORS'(1) << w_serve_floor) :
                    '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_floor   <= 4'd0;
      r_dir_up  <= 1'b1;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_floor   <= w_floor_nx;
      r_dir_up  <= w_dir_nx;
      r_pending <= (r_pending | call_req) & ~w_served;
    end
  end

  assign floor_bcd   = r_floor;
  assign pending     = r_pending;
  assign door_open   = (r_state == DOOR);
  assign moving_up   = (r_state == MOVE_UP);
  assign moving_down = (r_state == MOVE_DOWN);

endmodule
